// File: rtl/lcd_timing_receiver.sv
// rtl/lcd_timing_receiver.sv - LCD sync/DE timing receiver: pixel stream recovery, timing measurement, lock tracking
module lcd_timing_receiver #(
   parameter int H_PERIOD    = 531,
   parameter int H_ACTIVE    = 480,
   parameter int V_PERIOD    = 288,
   parameter int V_ACTIVE    = 272,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        i_clk,
   input  logic        i_res_n,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic        i_de,
   input  logic [15:0] i_data,
   output logic        o_pix_valid,
   output logic [9:0]  o_pix_x,
   output logic [8:0]  o_pix_y,
   output logic [15:0] o_pix_data,
   output logic [9:0]  o_line_period,
   output logic [9:0]  o_active_width,
   output logic [8:0]  o_frame_lines,
   output logic [8:0]  o_active_lines,
   output logic        o_frame_start,
   output logic        o_locked,
   output logic        o_err,
   output logic [7:0]  o_err_cnt
);
   localparam logic [9:0] C_H_PERIOD = 10'(H_PERIOD);
   localparam logic [9:0] C_H_ACTIVE = 10'(H_ACTIVE);
   localparam logic [8:0] C_V_PERIOD = 9'(V_PERIOD);
   localparam logic [8:0] C_V_ACTIVE = 9'(V_ACTIVE);
   localparam logic [7:0] C_LOCK     = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

   logic        r_hs, r_vs, r_de, r_hs_d, r_vs_d, r_de_d;
   logic [15:0] r_data;
   logic [9:0]  r_hcnt, r_derun, r_x;
   logic [8:0]  r_y, r_lines, r_alines;
   logic        r_line_bad;
   state_t      r_state, w_state_nxt;
   logic [7:0]  r_good, w_good_nxt, w_good_inc;
   logic        w_err_now;

   logic        w_ls, w_fs, w_de_fall, w_line_err, w_frame_err;
   logic [9:0]  w_hcnt_inc, w_run_base, w_run_inc, w_x_cur, w_x_inc;
   logic [8:0]  w_y_cur, w_y_inc, w_lines_inc, w_alines_inc, w_fl, w_al;

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         r_hs   <= 1'b0;
         r_vs   <= 1'b0;
         r_de   <= 1'b0;
         r_data <= 16'd0;
         r_hs_d <= 1'b0;
         r_vs_d <= 1'b0;
         r_de_d <= 1'b0;
      end else begin
         r_hs   <= i_hsync;
         r_vs   <= i_vsync;
         r_de   <= i_de;
         r_data <= i_data;
         r_hs_d <= r_hs;
         r_vs_d <= r_vs;
         r_de_d <= r_de;
      end
   end

   assign w_ls         = r_hs_d & ~r_hs;
   assign w_fs         = r_vs_d & ~r_vs;
   assign w_de_fall    = r_de_d & ~r_de;
   assign w_hcnt_inc   = (r_hcnt == 10'h3FF) ? r_hcnt : r_hcnt + 10'd1;
   assign w_run_base   = (w_ls | ~r_de_d) ? 10'd0 : r_derun;
   assign w_run_inc    = (w_run_base == 10'h3FF) ? w_run_base : w_run_base + 10'd1;
   assign w_x_cur      = w_ls ? 10'd0 : r_x;
   assign w_x_inc      = (w_x_cur == 10'h3FF) ? w_x_cur : w_x_cur + 10'd1;
   assign w_y_cur      = w_fs ? 9'd0 : r_y;
   assign w_y_inc      = (r_y == 9'h1FF) ? r_y : r_y + 9'd1;
   assign w_lines_inc  = (r_lines == 9'h1FF) ? r_lines : r_lines + 9'd1;
   assign w_alines_inc = (r_alines == 9'h1FF) ? r_alines : r_alines + 9'd1;
   // A line or DE run closing in the frame-start cycle still belongs to the frame being closed
   assign w_fl         = w_ls ? w_lines_inc : r_lines;
   assign w_al         = w_de_fall ? w_alines_inc : r_alines;
   assign w_line_err   = (w_ls & (w_hcnt_inc != C_H_PERIOD)) |
                         (w_de_fall & (r_derun != C_H_ACTIVE));
   assign w_frame_err  = (w_fl != C_V_PERIOD) | (w_al != C_V_ACTIVE) | r_line_bad | w_line_err;
   assign w_good_inc   = r_good + 8'd1;

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         r_hcnt         <= 10'd0;
         r_derun        <= 10'd0;
         r_lines        <= 9'd0;
         r_alines       <= 9'd0;
         r_line_bad     <= 1'b0;
         o_line_period  <= 10'd0;
         o_active_width <= 10'd0;
         o_frame_lines  <= 9'd0;
         o_active_lines <= 9'd0;
      end else begin
         if (w_ls) begin
            r_hcnt        <= 10'd0;
            o_line_period <= w_hcnt_inc;
         end else begin
            r_hcnt <= w_hcnt_inc;
         end
         if (r_de) r_derun <= w_run_inc;
         else if (w_ls) r_derun <= 10'd0;
         if (w_de_fall) o_active_width <= r_derun;
         if (w_fs) begin
            r_lines        <= 9'd0;
            r_alines       <= 9'd0;
            o_frame_lines  <= w_fl;
            o_active_lines <= w_al;
         end else begin
            if (w_ls) r_lines <= w_lines_inc;
            if (w_de_fall) r_alines <= w_alines_inc;
         end
         if (w_fs) r_line_bad <= 1'b0;
         else if (w_line_err && (r_state != SEARCH)) r_line_bad <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         r_x         <= 10'd0;
         r_y         <= 9'd0;
         o_pix_valid <= 1'b0;
         o_pix_x     <= 10'd0;
         o_pix_y     <= 9'd0;
         o_pix_data  <= 16'd0;
      end else begin
         o_pix_valid <= r_de;
         if (r_de) begin
            o_pix_x    <= w_x_cur;
            o_pix_y    <= w_y_cur;
            o_pix_data <= r_data;
            r_x        <= w_x_inc;
         end else if (w_ls) begin
            r_x <= 10'd0;
         end
         if (w_fs) r_y <= 9'd0;
         else if (w_de_fall) r_y <= w_y_inc;
      end
   end

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         r_state <= SEARCH;
         r_good  <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_good  <= w_good_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_err_now   = 1'b0;
      case (r_state)
         SEARCH: begin
            if (w_fs) begin
               w_state_nxt = CHECK;
               w_good_nxt  = 8'd0;
            end
         end
         CHECK: begin
            if (w_fs) begin
               if (w_frame_err) begin
                  w_good_nxt = 8'd0;
               end else begin
                  w_good_nxt = w_good_inc;
                  if (w_good_inc >= C_LOCK) w_state_nxt = LOCKED;
               end
            end
         end
         LOCKED: begin
            // Leaving LOCKED on the first error is what limits a burst to one o_err pulse
            if (w_line_err || (w_fs && w_frame_err)) begin
               w_err_now   = 1'b1;
               w_state_nxt = CHECK;
               w_good_nxt  = 8'd0;
            end
         end
         default: begin
            w_state_nxt = SEARCH;
            w_good_nxt  = 8'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         o_frame_start <= 1'b0;
         o_locked      <= 1'b0;
         o_err         <= 1'b0;
         o_err_cnt     <= 8'd0;
      end else begin
         o_frame_start <= w_fs;
         o_locked      <= (w_state_nxt == LOCKED);
         o_err         <= w_err_now;
         if (w_err_now && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_lcd_timing_receiver.sv
// tb/tb_lcd_timing_receiver.sv - randomized self-checking bench for lcd_timing_receiver
module tb_lcd_timing_receiver;
   localparam int HP       = 60;
   localparam int HA       = 40;
   localparam int VP       = 20;
   localparam int VA       = 12;
   localparam int DE_H0    = 12;
   localparam int DE_V0    = 4;
   localparam int VS_LINES = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hsync = 1'b1, vsync = 1'b1, de = 1'b0;
   logic [15:0] data = 16'd0;
   logic        o_pix_valid, o_frame_start, o_locked, o_err;
   logic [9:0]  o_pix_x, o_line_period, o_active_width;
   logic [8:0]  o_pix_y, o_frame_lines, o_active_lines;
   logic [15:0] o_pix_data;
   logic [7:0]  o_err_cnt;

   lcd_timing_receiver #(
      .H_PERIOD(HP), .H_ACTIVE(HA), .V_PERIOD(VP), .V_ACTIVE(VA), .LOCK_FRAMES(2)
   ) dut (
      .i_clk(clk), .i_res_n(rst_n), .i_hsync(hsync), .i_vsync(vsync), .i_de(de), .i_data(data),
      .o_pix_valid(o_pix_valid), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_pix_data(o_pix_data),
      .o_line_period(o_line_period), .o_active_width(o_active_width),
      .o_frame_lines(o_frame_lines), .o_active_lines(o_active_lines),
      .o_frame_start(o_frame_start), .o_locked(o_locked), .o_err(o_err), .o_err_cnt(o_err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     x;
      int     y;
      int     d;
      longint edge_no;
   } pix_t;

   pix_t   exp_q[$];
   int     n_cmp = 0, n_mis = 0;
   longint edge_cnt = 0;
   int     fs_cnt = 0, n_err = 0, lock_fs = -1;
   logic   prev_lock = 1'b0;
   int     model_x = 0, model_y = 0;
   logic   prev_de = 1'b0;

   task automatic check(input string tag, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_zero_outputs();
      check("rst_pix", longint'({o_pix_valid, o_pix_x, o_pix_y, o_pix_data}), 0);
      check("rst_meas", longint'({o_line_period, o_active_width, o_frame_lines, o_active_lines}), 0);
      check("rst_status", longint'({o_frame_start, o_err, o_err_cnt}), 0);
      check("rst_locked", longint'(o_locked), 0);
   endtask

   // Drive one clock of input, then observe outputs away from the edge
   task automatic tick(input logic hs, input logic vs, input logic d_en, input logic [15:0] d);
      pix_t e;
      hsync = hs;
      vsync = vs;
      de    = d_en;
      data  = d;
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
      if (o_frame_start) fs_cnt++;
      if (o_err) n_err++;
      if (o_locked && !prev_lock) lock_fs = fs_cnt;
      prev_lock = o_locked;
      if (o_pix_valid) begin
         if (exp_q.size() == 0) begin
            check("pix_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("pix_latency", edge_cnt, e.edge_no);
            check("pix_x", longint'(o_pix_x), e.x);
            check("pix_y", longint'(o_pix_y), e.y);
            check("pix_data", longint'(o_pix_data), e.d);
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_zero_outputs();
      exp_q.delete();
      model_x   = 0;
      model_y   = 0;
      fs_cnt    = 0;
      n_err     = 0;
      lock_fs   = -1;
      prev_lock = 1'b0;
      repeat (2) begin
         @(posedge clk);
         edge_cnt++;
      end
      @(negedge clk);
      check_zero_outputs();
      rst_n = 1'b1;
   endtask

   // One frame: hsync low at h=0, vsync low on the first lines, DE on the active window.
   // Special lines (-1 = none): short period, one-short DE run, very long line, reset point.
   task automatic drive_frame(input int short_ln, input int narrow_ln, input int long_ln,
                              input int rst_ln);
      for (int l = 0; l < VP; l++) begin
         int per;
         int de_end;
         per    = (l == short_ln) ? HP - 1 : ((l == long_ln) ? 1100 : HP);
         de_end = DE_H0 + ((l == narrow_ln) ? HA - 1 : HA);
         for (int h = 0; h < per; h++) begin
            logic        d_en;
            logic [15:0] d;
            pix_t        p;
            if (l == rst_ln && h == 10) do_reset();
            d_en = (l >= DE_V0) && (l < DE_V0 + VA) && (h >= DE_H0) && (h < de_end);
            d    = 16'($urandom);
            if (h == 0) model_x = 0;
            if (l == 0 && h == 0) model_y = 0;
            if (prev_de && !d_en) model_y = (model_y < 511) ? model_y + 1 : 511;
            if (d_en) begin
               p.x       = model_x;
               p.y       = model_y;
               p.d       = int'(d);
               p.edge_no = edge_cnt + 2;
               exp_q.push_back(p);
               model_x = (model_x < 1023) ? model_x + 1 : 1023;
            end
            prev_de = d_en;
            tick(h != 0, l >= VS_LINES, d_en, d);
            if (l == narrow_ln && h == per - 1)
               check("narrow_width", longint'(o_active_width), HA - 1);
            if (long_ln >= 0 && l == long_ln + 1 && h == 5) begin
               check("sat_line_period", longint'(o_line_period), 1023);
               check("no_err_outside_lock", n_err, 2);
            end
         end
      end
   endtask

   task automatic check_meas(input string tag);
      check({tag, "_line_period"}, longint'(o_line_period), HP);
      check({tag, "_active_width"}, longint'(o_active_width), HA);
      check({tag, "_frame_lines"}, longint'(o_frame_lines), VP);
      check({tag, "_active_lines"}, longint'(o_active_lines), VA);
   endtask

   initial begin
      int short_ln, narrow_ln, rst_ln;
      short_ln  = int'($urandom_range(VP - 2, 1));
      narrow_ln = int'($urandom_range(DE_V0 + VA - 1, DE_V0));
      rst_ln    = int'($urandom_range(VP - 3, 4));

      repeat (3) @(negedge clk);
      check_zero_outputs();
      rst_n = 1'b1;
      repeat (5) tick(1'b1, 1'b1, 1'b0, 16'd0);

      drive_frame(-1, -1, -1, -1);
      drive_frame(-1, -1, -1, -1);
      check("locked_before_3rd_fs", longint'(o_locked), 0);
      drive_frame(-1, -1, -1, -1);
      check("lock_at_fs", lock_fs, 3);
      check("locked", longint'(o_locked), 1);
      check("fs_pulses", fs_cnt, 3);
      check_meas("ideal");
      check("err_cnt_clean", longint'(o_err_cnt), 0);

      drive_frame(short_ln, -1, -1, -1);
      check("short_err_pulses", n_err, 1);
      check("short_err_cnt", longint'(o_err_cnt), 1);
      check("short_unlocked", longint'(o_locked), 0);
      drive_frame(-1, -1, -1, -1);
      drive_frame(-1, -1, -1, -1);
      check("relock_not_yet", longint'(o_locked), 0);
      drive_frame(-1, -1, -1, -1);
      check("relocked", longint'(o_locked), 1);
      check("relock_err_pulses", n_err, 1);

      drive_frame(-1, narrow_ln, -1, -1);
      check("narrow_err_pulses", n_err, 2);
      check("narrow_err_cnt", longint'(o_err_cnt), 2);
      check("narrow_unlocked", longint'(o_locked), 0);

      drive_frame(-1, -1, 2, rst_ln);
      drive_frame(-1, -1, -1, -1);
      drive_frame(-1, -1, -1, -1);
      check("rst_locked_before_3rd_fs", longint'(o_locked), 0);
      drive_frame(-1, -1, -1, -1);
      check("rst_lock_at_fs", lock_fs, 3);
      check("rst_relocked", longint'(o_locked), 1);
      check("rst_no_err", n_err, 0);
      check("rst_err_cnt", longint'(o_err_cnt), 0);
      check_meas("after_rst");

      repeat (4) tick(1'b1, 1'b1, 1'b0, 16'd0);
      check("pix_missing", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
